// File: rtl/bus_arbiter.sv
// Time-slot arbiter sharing one RAM port between a 6502 core (odd slots) and a video fetch engine (even slots).
// A video burst warns the CPU for WARN_CYC slots, then takes every cycle until the burst length is spent.
module bus_arbiter #(
    parameter int WARN_CYC = 3,
    parameter int LEN_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      cpu_ab,
    input  logic [7:0]       cpu_do,
    input  logic             cpu_we,
    output logic [7:0]       cpu_di,
    output logic             cpu_ce,
    input  logic             vid_req,
    input  logic [15:0]      vid_addr,
    output logic             vid_ack,
    input  logic             vid_burst,
    input  logic [LEN_W-1:0] vid_len,
    output logic             vid_valid,
    output logic [7:0]       vid_data,
    output logic             ba_n,
    output logic [15:0]      ram_ab,
    output logic [7:0]       ram_do,
    output logic             ram_we,
    input  logic [7:0]       ram_di
);

    localparam int WARN_W = (WARN_CYC < 2) ? 1 : $clog2(WARN_CYC + 1);
    localparam logic [WARN_W-1:0] WARN_INIT = WARN_W'(WARN_CYC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WARN  = 2'd1,
        ST_STEAL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic [WARN_W-1:0]  warn_cnt_q, warn_cnt_d;
    logic [LEN_W-1:0]   len_lat_q, len_lat_d;
    logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
    logic               ba_n_q, ba_n_d;
    logic               vid_valid_q, vid_valid_d;
    logic               rd_pend_q, rd_pend_d;
    logic [7:0]         cpu_di_q, cpu_di_d;

    logic               ce_raw;
    logic               ack_raw;
    logic               we_raw;
    logic [15:0]        ab_raw;
    logic [LEN_W-1:0]   eff_len;

    // Slot decode: who owns the RAM port this cycle.
    always_comb begin
        ce_raw  = 1'b0;
        ack_raw = 1'b0;
        we_raw  = 1'b0;
        ab_raw  = cpu_ab;
        case (state_q)
            ST_IDLE, ST_WARN: begin
                if (phase_q) begin
                    ce_raw = 1'b1;
                    we_raw = cpu_we;
                end else if (vid_req) begin
                    ab_raw  = vid_addr;
                    ack_raw = 1'b1;
                end else begin
                    ab_raw = cpu_ab;
                end
            end
            ST_STEAL: begin
                ab_raw  = vid_addr;
                ack_raw = 1'b1;
            end
            default: begin
                ab_raw = cpu_ab;
            end
        endcase
    end

    // Reset forces the bus-facing strobes quiet immediately, not at the next edge.
    assign cpu_ce    = ce_raw & ~reset;
    assign vid_ack   = ack_raw & ~reset;
    assign ram_we    = we_raw & ~reset;
    assign ram_ab    = reset ? 16'h0000 : ab_raw;
    assign ram_do    = cpu_do;
    assign vid_data  = ram_di;
    assign vid_valid = vid_valid_q;
    assign ba_n      = ba_n_q;
    assign cpu_di    = cpu_di_q;

    assign eff_len = (vid_len == '0) ? LEN_W'(1) : vid_len;

    // Next-state: burst acceptance, warning countdown, steal countdown and read-data capture.
    always_comb begin
        state_d     = state_q;
        phase_d     = ~phase_q;
        warn_cnt_d  = warn_cnt_q;
        len_lat_d   = len_lat_q;
        len_cnt_d   = len_cnt_q;
        ba_n_d      = ba_n_q;
        vid_valid_d = ack_raw;
        rd_pend_d   = ce_raw & ~cpu_we;
        if (rd_pend_q) begin
            cpu_di_d = ram_di;
        end else begin
            cpu_di_d = cpu_di_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (!phase_q && vid_burst) begin
                    len_lat_d  = eff_len;
                    warn_cnt_d = WARN_INIT;
                    ba_n_d     = 1'b0;
                    if (WARN_CYC == 0) begin
                        state_d   = ST_STEAL;
                        len_cnt_d = eff_len;
                    end else begin
                        state_d = ST_WARN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WARN: begin
                if (phase_q) begin
                    warn_cnt_d = warn_cnt_q - WARN_W'(1);
                    if (warn_cnt_q <= WARN_W'(1)) begin
                        state_d   = ST_STEAL;
                        len_cnt_d = len_lat_q;
                    end else begin
                        state_d = ST_WARN;
                    end
                end else begin
                    state_d = ST_WARN;
                end
            end
            ST_STEAL: begin
                len_cnt_d = len_cnt_q - LEN_W'(1);
                if (len_cnt_q <= LEN_W'(1)) begin
                    state_d = ST_IDLE;
                    ba_n_d  = 1'b1;
                end else begin
                    state_d = ST_STEAL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ba_n_d  = 1'b1;
            end
        endcase
    end

    // State registers; a reset mid-burst simply drops the burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            warn_cnt_q  <= '0;
            len_lat_q   <= '0;
            len_cnt_q   <= '0;
            ba_n_q      <= 1'b1;
            vid_valid_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            cpu_di_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            warn_cnt_q  <= warn_cnt_d;
            len_lat_q   <= len_lat_d;
            len_cnt_q   <= len_cnt_d;
            ba_n_q      <= ba_n_d;
            vid_valid_q <= vid_valid_d;
            rd_pend_q   <= rd_pend_d;
            cpu_di_q    <= cpu_di_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: default build (WARN_CYC=3) plus a WARN_CYC=0 build on shared stimulus.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_ab = 16'h0000;
    logic [7:0]  cpu_do = 8'h00;
    logic        cpu_we = 1'b0;
    logic        vid_req = 1'b0;
    logic [15:0] vid_addr = 16'h0000;
    logic        vid_burst = 1'b0;
    logic [5:0]  vid_len = 6'd0;

    logic [7:0]  cpu_di, vid_data, ram_do, ram_di;
    logic        cpu_ce, vid_ack, vid_valid, ba_n, ram_we;
    logic [15:0] ram_ab;
    logic [7:0]  cpu_di2, vid_data2, ram_do2, ram_di2;
    logic        cpu_ce2, vid_ack2, vid_valid2, ba_n2, ram_we2;
    logic [15:0] ram_ab2;

    always #5 clk = ~clk;

    bus_arbiter #(.WARN_CYC(3), .LEN_W(6)) dut (
        .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
        .cpu_di(cpu_di), .cpu_ce(cpu_ce), .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_ack(vid_ack), .vid_burst(vid_burst), .vid_len(vid_len), .vid_valid(vid_valid),
        .vid_data(vid_data), .ba_n(ba_n), .ram_ab(ram_ab), .ram_do(ram_do), .ram_we(ram_we),
        .ram_di(ram_di)
    );

    bus_arbiter #(.WARN_CYC(0), .LEN_W(6)) dut0 (
        .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
        .cpu_di(cpu_di2), .cpu_ce(cpu_ce2), .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_ack(vid_ack2), .vid_burst(vid_burst), .vid_len(vid_len), .vid_valid(vid_valid2),
        .vid_data(vid_data2), .ba_n(ba_n2), .ram_ab(ram_ab2), .ram_do(ram_do2), .ram_we(ram_we2),
        .ram_di(ram_di2)
    );

    // Power-on RAM image: program bytes at 0..4, a simple address pattern elsewhere.
    function automatic logic [7:0] init_val(input logic [15:0] a);
        case (a)
            16'h0000: return 8'hA9;
            16'h0001: return 8'h23;
            16'h0002: return 8'h8D;
            16'h0003: return 8'h00;
            16'h0004: return 8'h13;
            default:  return a[7:0] + 8'h5A;
        endcase
    endfunction

    logic [7:0] mem  [0:65535];
    bit         wr_v [0:65535];
    logic [7:0] mem2 [0:65535];
    bit         wr_v2[0:65535];

    // Synchronous-read RAM models, one per arbiter.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_ab]  <= ram_do;
            wr_v[ram_ab] <= 1'b1;
        end
        ram_di <= wr_v[ram_ab] ? mem[ram_ab] : init_val(ram_ab);
    end

    always @(posedge clk) begin
        if (ram_we2) begin
            mem2[ram_ab2]  <= ram_do2;
            wr_v2[ram_ab2] <= 1'b1;
        end
        ram_di2 <= wr_v2[ram_ab2] ? mem2[ram_ab2] : init_val(ram_ab2);
    end

    function automatic logic [7:0] ram_rd(input logic [15:0] a);
        return wr_v[a] ? mem[a] : init_val(a);
    endfunction

    logic [7:0] gold [int];

    function automatic logic [7:0] gold_rd(input logic [15:0] a);
        if (gold.exists(int'(a))) return gold[int'(a)];
        return init_val(a);
    endfunction

    typedef struct packed {
        logic chk2;
        logic rst;
        logic ce;
        logic ack;
        logic ban;
        logic we;
        logic ce2;
        logic ack2;
        logic ban2;
    } ctl_t;

    ctl_t       ctl_q[$];
    logic [7:0] vid_q[$];
    logic [7:0] vid2_q[$];
    logic [7:0] rd_q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    bit         vid2_en = 1'b0;
    bit         end_req = 1'b0;
    bit         end_done = 1'b0;

    // Push the hand-derived expectation for the current cycle, then advance one clock.
    task automatic cyc(input logic ce, input logic ack, input logic ban,
                       input logic chk2 = 1'b0, input logic ce2 = 1'b0,
                       input logic ack2 = 1'b0, input logic ban2 = 1'b1);
        ctl_t e;
        e.chk2 = chk2; e.rst = reset; e.ce = ce; e.ack = ack; e.ban = ban;
        e.we = ce & cpu_we; e.ce2 = ce2; e.ack2 = ack2; e.ban2 = ban2;
        ctl_q.push_back(e);
        if (ack) vid_q.push_back(gold_rd(vid_addr));
        if (chk2 && ack2) vid2_q.push_back(gold_rd(vid_addr));
        if (ce && !cpu_we) rd_q.push_back(gold_rd(cpu_ab));
        if (ce && cpu_we) gold[int'(cpu_ab)] = cpu_do;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Monitor: compares control outputs per cycle and data whenever the DUT presents it.
    initial begin : monitor
        ctl_t       e;
        logic       p1 = 1'b0, p2 = 1'b0;
        logic [7:0] v1 = 8'h00, v2 = 8'h00;
        forever begin
            @(negedge clk);
            if (p2) check("cpu_di", 32'(cpu_di), 32'(v2));
            p2 = p1;
            v2 = v1;
            p1 = 1'b0;
            if (ctl_q.size() > 0) begin
                e = ctl_q.pop_front();
                check("ctl{ce,ack,ba_n,we}", {28'h0, cpu_ce, vid_ack, ba_n, ram_we},
                      {28'h0, e.ce, e.ack, e.ban, e.we});
                if (e.rst) check("reset_outputs", {7'h0, ram_ab, cpu_di, vid_valid},
                                 {7'h0, 16'h0000, 8'h00, 1'b0});
                if (e.chk2) check("ctl0{ce,ack,ba_n,we}", {28'h0, cpu_ce2, vid_ack2, ba_n2, ram_we2},
                                  {28'h0, e.ce2, e.ack2, e.ban2, 1'b0});
                if (e.chk2 && e.rst) check("reset_outputs0", {7'h0, ram_ab2, cpu_di2, vid_valid2},
                                           {7'h0, 16'h0000, 8'h00, 1'b0});
                if (cpu_ce && !cpu_we) begin
                    if (rd_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL cpu_rd_unexp: CPU read slot at %h not expected", ram_ab);
                    end else begin
                        p1 = 1'b1;
                        v1 = rd_q.pop_front();
                    end
                end
            end
            if (vid_valid) begin
                if (vid_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL vid_unexp: vid_valid with data %h, none expected", vid_data);
                end else begin
                    check("vid_data", 32'(vid_data), 32'(vid_q.pop_front()));
                end
            end
            if (vid2_en && vid_valid2) begin
                if (vid2_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL vid0_unexp: vid_valid with data %h, none expected", vid_data2);
                end else begin
                    check("vid0_data", 32'(vid_data2), 32'(vid2_q.pop_front()));
                end
            end
            if (end_req && !end_done) begin
                check("ram_1300", 32'(ram_rd(16'h1300)), 32'h23);
                check("ram_000c", 32'(ram_rd(16'h000C)), 32'h77);
                check("ctl_left", ctl_q.size(), 32'd0);
                check("vid_left", vid_q.size(), 32'd0);
                check("vid0_left", vid2_q.size(), 32'd0);
                check("rd_left", rd_q.size(), 32'd0);
                end_done = 1'b1;
            end
        end
    end

    logic [15:0] op_ab [8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                               16'h0004, 16'h1300, 16'h0005, 16'h0006};
    logic        op_we [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin : stim
        @(posedge clk);
        #1;
        // Reset with live requests: outputs must stay quiet.
        vid_req = 1'b1; vid_addr = 16'h0400; cpu_ab = 16'h1234;
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        vid_req = 1'b0;

        // LDA #$23 / STA $1300 bus pattern, CPU on odd slots only.
        for (int i = 0; i < 8; i++) begin
            cpu_ab = op_ab[i]; cpu_we = op_we[i]; cpu_do = 8'h23;
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b1, 1'b0, 1'b1);
        end
        cpu_we = 1'b0;

        // Single video fetches interleaved with CPU reads.
        vid_req = 1'b1; vid_addr = 16'h0400; cpu_ab = 16'h0010;
        repeat (4) begin
            cyc(1'b0, 1'b1, 1'b1);
            cyc(1'b1, 1'b0, 1'b1);
        end
        vid_req = 1'b0;

        // Burst of 40: three warning CPU slots (one a write), then 40 stolen cycles.
        vid_burst = 1'b1; vid_len = 6'd40; cpu_ab = 16'h0020;
        cyc(1'b0, 1'b0, 1'b1);
        vid_burst = 1'b0;
        cpu_ab = 16'h000C; cpu_we = 1'b1; cpu_do = 8'h77;
        cyc(1'b1, 1'b0, 1'b0);
        cpu_we = 1'b0; vid_burst = 1'b1; vid_len = 6'd5;
        cyc(1'b0, 1'b0, 1'b0);
        vid_burst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cpu_ab = 16'h0030;
        cyc(1'b1, 1'b0, 1'b0);
        cpu_ab = 16'h000C; cpu_we = 1'b1; cpu_do = 8'hEE;
        for (int i = 0; i < 40; i++) begin
            vid_addr = 16'h0400 + 16'(i);
            cyc(1'b0, 1'b1, 1'b0);
        end
        cpu_we = 1'b0; vid_addr = 16'h0400; cpu_ab = 16'h0040;
        repeat (2) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b1, 1'b0, 1'b1);
        end

        // Reset in the middle of a steal with 20 fetches left.
        vid_burst = 1'b1; vid_len = 6'd40;
        cyc(1'b0, 1'b0, 1'b1);
        vid_burst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            vid_addr = 16'h0500 + 16'(i);
            cyc(1'b0, 1'b1, 1'b0);
        end
        reset = 1'b1;
        vid_q.delete();
        vid_req = 1'b1; cpu_we = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        vid_req = 1'b0; cpu_we = 1'b0; cpu_ab = 16'h0040;
        repeat (3) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b1, 1'b0, 1'b1);
        end

        // vid_len=0 on both builds: one steal cycle, immediate for WARN_CYC=0.
        vid2_en = 1'b1;
        vid_addr = 16'h0410; cpu_ab = 16'h0050; vid_burst = 1'b1; vid_len = 6'd0;
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        vid_burst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_done; i++) @(posedge clk);
        if (!end_done) begin
            $display("FAIL end_wait: final checks not reached, got 0 expected 1");
            $fatal(1);
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
